// File: rtl/midi_in_rx.sv
// -----------------------------------------------------------------------------
// midi_in_rx
//   MIDI serial receiver (8N1, LSB first, 31250 baud at 50 MHz by default).
//   Received bytes are assembled into 3-byte channel messages. Running status
//   is supported. Realtime bytes (F8-FF) are ignored.
//
// Ports
//   clk        : system clock. All logic runs on the rising edge.
//   reset      : asynchronous, active-high reset.
//   serial     : MIDI line. Idle high. Asynchronous to clk.
//   out_bytes  : last complete message {status, data1, data2}.
//   out_valid  : one-cycle pulse when out_bytes updates.
//   frame_err  : one-cycle pulse when a stop bit samples low.
//   state      : current receiver FSM state (debug).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module midi_in_rx #(
   parameter int CLKS_PER_BIT = 1600,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        serial,
   output logic [23:0] out_bytes,
   output logic        out_valid,
   output logic        frame_err,
   output logic [3:0]  state
);

   // Sized so the counter reaches CLKS_PER_BIT-1 without wrapping.
   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_START     = 4'd1,
      ST_DATA      = 4'd2,
      ST_STOP      = 4'd3,
      ST_WAIT_HIGH = 4'd4
   } state_t;

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   line_s;

   state_t           state_r;
   logic [CNT_W-1:0] clk_cnt_r;
   logic [2:0]       bit_idx_r;
   logic [7:0]       shift_r;
   logic [7:0]       status_r;
   logic             have_status_r;
   logic [7:0]       data1_r;
   logic             idx_r;
   logic [23:0]      out_bytes_r;
   logic             out_valid_r;
   logic             frame_err_r;

   // Input synchronizer. Reset loads ones so a reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], serial};
      end
   end

   assign line_s = sync_r[SYNC_STAGES-1];

   // Receiver FSM, byte shifter, and message assembly, with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         clk_cnt_r     <= CNT_ZERO;
         bit_idx_r     <= 3'd0;
         shift_r       <= 8'h00;
         status_r      <= 8'h00;
         have_status_r <= 1'b0;
         data1_r       <= 8'h00;
         idx_r         <= 1'b0;
         out_bytes_r   <= 24'h000000;
         out_valid_r   <= 1'b0;
         frame_err_r   <= 1'b0;
      end else begin
         out_valid_r <= 1'b0;
         frame_err_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               clk_cnt_r <= CNT_ZERO;
               if (!line_s) begin
                  state_r <= ST_START;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_START: begin
               // Resample at half a bit. This rejects glitches and aligns
               // later samples to mid-bit.
               if (clk_cnt_r == HALF_LAST) begin
                  clk_cnt_r <= CNT_ZERO;
                  bit_idx_r <= 3'd0;
                  if (!line_s) begin
                     state_r <= ST_DATA;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_ONE;
               end
            end
            ST_DATA: begin
               if (clk_cnt_r == FULL_LAST) begin
                  clk_cnt_r <= CNT_ZERO;
                  shift_r   <= {line_s, shift_r[7:1]};
                  if (bit_idx_r == 3'd7) begin
                     state_r <= ST_STOP;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_ONE;
               end
            end
            ST_STOP: begin
               if (clk_cnt_r == FULL_LAST) begin
                  clk_cnt_r <= CNT_ZERO;
                  if (line_s) begin
                     state_r <= ST_IDLE;
                     if (shift_r >= 8'hF8) begin
                        // Realtime byte: leaves message assembly untouched.
                        idx_r <= idx_r;
                     end else if (shift_r[7]) begin
                        status_r      <= shift_r;
                        have_status_r <= 1'b1;
                        idx_r         <= 1'b0;
                     end else if (!have_status_r) begin
                        idx_r <= 1'b0;
                     end else if (!idx_r) begin
                        data1_r <= shift_r;
                        idx_r   <= 1'b1;
                     end else begin
                        // Status is kept so that running status works.
                        out_bytes_r <= {status_r, data1_r, shift_r};
                        out_valid_r <= 1'b1;
                        idx_r       <= 1'b0;
                     end
                  end else begin
                     frame_err_r <= 1'b1;
                     state_r     <= ST_WAIT_HIGH;
                  end
               end else begin
                  clk_cnt_r <= clk_cnt_r + CNT_ONE;
               end
            end
            ST_WAIT_HIGH: begin
               if (line_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_WAIT_HIGH;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_bytes = out_bytes_r;
   assign out_valid = out_valid_r;
   assign frame_err = frame_err_r;
   assign state     = state_r;

endmodule

// File: tb/tb_midi_in_rx.sv
`timescale 1ns/1ps

module tb_midi_in_rx;

   localparam int CPB    = 32;         // shortened bit time keeps the run small
   localparam int CLK_NS = 20;
   localparam int BIT_NS = CPB * CLK_NS;

   logic        clk = 1'b0;
   logic        reset;
   logic        serial;
   logic [23:0] out_bytes;
   logic        out_valid;
   logic        frame_err;
   logic [3:0]  state;

   int total = 0;
   int bad   = 0;
   logic [23:0] sb_q[$];
   int ferr_pending = 0;
   int n_valid = 0;

   midi_in_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .serial    (serial),
      .out_bytes (out_bytes),
      .out_valid (out_valid),
      .frame_err (frame_err),
      .state     (state)
   );

   always #(CLK_NS/2) clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each out_valid and checks frame_err pulses.
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         n_valid++;
         if (sb_q.size() == 0) begin
            check("unexpected_out_valid", {8'h00, out_bytes}, 32'hFFFFFFFF);
         end else begin
            check("out_bytes", {8'h00, out_bytes}, {8'h00, sb_q.pop_front()});
         end
      end
      if (frame_err === 1'b1) begin
         check("frame_err_expected", (ferr_pending > 0) ? 32'd1 : 32'd0, 32'd1);
         if (ferr_pending > 0) ferr_pending--;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_level);
      serial = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         serial = b[i];
         #(BIT_NS);
      end
      serial = stop_level;
      #(BIT_NS);
      if (stop_level) serial = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 4 * CPB && sb_q.size() != 0; i++) @(posedge clk);
      check(name, sb_q.size(), 32'd0);
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b1;
      serial = 1'b1;
      #53;
      check("rst_out_bytes", {8'h00, out_bytes}, 32'h0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_state", {28'd0, state}, 32'd0);
      reset = 1'b0;
      #1320;

      // 1: basic message
      send_byte(8'h90, 1'b1);
      send_byte(8'h04, 1'b1);
      sb_q.push_back(24'h90047F);
      send_byte(8'h7F, 1'b1);
      wait_drain("t1_drain");

      // 2: running status
      send_byte(8'h3C, 1'b1);
      sb_q.push_back(24'h903C40);
      send_byte(8'h40, 1'b1);
      wait_drain("t2_drain");

      // 3: short low glitch on the idle line
      serial = 1'b0;
      #(8 * CLK_NS);
      serial = 1'b1;
      #(2 * BIT_NS);
      check("t3_state_idle", {28'd0, state}, 32'd0);
      check("t3_out_bytes_held", {8'h00, out_bytes}, 32'h00903C40);

      // 4: framing error then recovery
      ferr_pending = 1;
      send_byte(8'h90, 1'b0);
      #(BIT_NS);
      check("t4_state_wait_high", {28'd0, state}, 32'd4);
      check("t4_ferr_seen", ferr_pending, 32'd0);
      serial = 1'b1;
      #(10 * CLK_NS);
      check("t4_state_idle", {28'd0, state}, 32'd0);
      send_byte(8'h80, 1'b1);
      send_byte(8'h01, 1'b1);
      sb_q.push_back(24'h800102);
      send_byte(8'h02, 1'b1);
      wait_drain("t4_drain");

      // 5: realtime byte between data bytes
      send_byte(8'h90, 1'b1);
      send_byte(8'h04, 1'b1);
      send_byte(8'hF8, 1'b1);
      sb_q.push_back(24'h90047F);
      send_byte(8'h7F, 1'b1);
      wait_drain("t5_drain");

      // 6: reset in the middle of the second byte
      send_byte(8'h90, 1'b1);
      serial = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         serial = (8'h04 >> i) & 8'h01;
         #(BIT_NS);
      end
      #(BIT_NS / 2);
      reset  = 1'b1;
      serial = 1'b1;
      #(5 * CLK_NS);
      check("t6_rst_out_bytes", {8'h00, out_bytes}, 32'h0);
      check("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("t6_rst_state", {28'd0, state}, 32'd0);
      reset = 1'b0;
      #(2 * BIT_NS);
      // Stored status was cleared: bare data bytes must be dropped.
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      #(BIT_NS);
      check("t6_no_status_out_bytes", {8'h00, out_bytes}, 32'h0);
      send_byte(8'h90, 1'b1);
      send_byte(8'h04, 1'b1);
      sb_q.push_back(24'h90047F);
      send_byte(8'h7F, 1'b1);
      wait_drain("t6_drain");

      #(2 * BIT_NS);
      check("valid_pulse_count", n_valid, 32'd5);
      check("ferr_pending_final", ferr_pending, 32'd0);
      check("final_out_bytes", {8'h00, out_bytes}, 32'h0090047F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
